mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_port_arbiter_if.sv | 54 +++++
 rtl/mem_arb_priority.sv | 19 +
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_DBG  = 1'b1
  } owner_e;

  localparam logic [2:0] FAULT_BUS_TIMEOUT = 3'b111;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Command latched at grant and replayed onto the memory port.
  typedef struct packed {
    logic        is_write;
    logic        is_unsigned;
    logic [1:0]  op_size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, debug and memory-side signals of the shared memory port.
interface mem_port_arbiter_if;

  logic        core_req;
  logic        core_is_write;
  logic        core_is_unsigned;
  logic [1:0]  core_op_size;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_ack;
  logic [31:0] core_rdata;
  logic [2:0]  core_fault_num;

  logic        dbg_req;
  logic        dbg_is_write;
  logic        dbg_is_unsigned;
  logic [1:0]  dbg_op_size;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic [2:0]  dbg_fault_num;

  logic        mem_enable_n;
  logic        mem_is_write;
  logic        mem_is_unsigned;
  logic [1:0]  mem_op_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_in;
  logic [31:0] mem_out;
  logic [2:0]  mem_fault_num;
  logic        mem_done;

  // Arbiter side.
  modport slave (
    input  core_req, core_is_write, core_is_unsigned, core_op_size, core_addr, core_wdata,
    output core_ack, core_rdata, core_fault_num,
    input  dbg_req, dbg_is_write, dbg_is_unsigned, dbg_op_size, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata, dbg_fault_num,
    output mem_enable_n, mem_is_write, mem_is_unsigned, mem_op_size, mem_addr, mem_in,
    input  mem_out, mem_fault_num, mem_done
  );

  // Requesters plus memory model side.
  modport master (
    output core_req, core_is_write, core_is_unsigned, core_op_size, core_addr, core_wdata,
    input  core_ack, core_rdata, core_fault_num,
    output dbg_req, dbg_is_write, dbg_is_unsigned, dbg_op_size, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata, dbg_fault_num,
    input  mem_enable_n, mem_is_write, mem_is_unsigned, mem_op_size, mem_addr, mem_in,
    output mem_out, mem_fault_num, mem_done
  );

endinterface

// File: rtl/mem_arb_priority.sv
// Winner select: core has priority unless debug has been starved for STARVE_LIMIT grants.
module mem_arb_priority #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic             core_req,
  input  logic             dbg_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             grant_core_c,
  output logic             grant_dbg_c
);

  logic starved_c;

  assign starved_c    = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign grant_dbg_c  = dbg_req & (~core_req | starved_c);
  assign grant_core_c = core_req & ~grant_dbg_c;

endmodule

// File: rtl/mem_port_arbiter.sv
// Grants the shared memory port to core or debug, holds the command until done/timeout,
// and returns data and fault status to the owner.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned WC_W = $clog2(TIMEOUT + 1);

  arb_state_e      state;
  owner_e          owner;
  mem_cmd_t        cmd;
  logic [WC_W-1:0] wait_cnt;
  logic [SC_W-1:0] starve_cnt;
  logic            enable_n;

  logic            core_ack;
  logic [31:0]     core_rdata;
  logic [2:0]      core_fault;
  logic            dbg_ack;
  logic [31:0]     dbg_rdata;
  logic [2:0]      dbg_fault;

  logic            grant_core_c;
  logic            grant_dbg_c;
  logic            finish_c;
  logic [31:0]     resp_rdata_c;
  logic [2:0]      resp_fault_c;
  mem_cmd_t        core_cmd_c;
  mem_cmd_t        dbg_cmd_c;

  assign core_cmd_c = {bus.core_is_write, bus.core_is_unsigned, bus.core_op_size,
                       bus.core_addr, bus.core_wdata};
  assign dbg_cmd_c  = {bus.dbg_is_write, bus.dbg_is_unsigned, bus.dbg_op_size,
                       bus.dbg_addr, bus.dbg_wdata};

  mem_arb_priority #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (SC_W)
  ) u_priority (
    .core_req     (bus.core_req),
    .dbg_req      (bus.dbg_req),
    .starve_cnt   (starve_cnt),
    .grant_core_c (grant_core_c),
    .grant_dbg_c  (grant_dbg_c)
  );

  // mem_done takes precedence over a timeout landing in the same cycle.
  assign finish_c     = bus.mem_done || (wait_cnt == WC_W'(TIMEOUT - 1));
  assign resp_rdata_c = bus.mem_done ? bus.mem_out : 32'd0;
  assign resp_fault_c = bus.mem_done ? bus.mem_fault_num : FAULT_BUS_TIMEOUT;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= OWNER_CORE;
      cmd        <= '0;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      enable_n   <= 1'b1;
      core_ack   <= 1'b0;
      core_rdata <= '0;
      core_fault <= '0;
      dbg_ack    <= 1'b0;
      dbg_rdata  <= '0;
      dbg_fault  <= '0;
    end else begin
      core_ack   <= 1'b0;
      core_rdata <= '0;
      core_fault <= '0;
      dbg_ack    <= 1'b0;
      dbg_rdata  <= '0;
      dbg_fault  <= '0;
      if (!bus.dbg_req) starve_cnt <= '0;

      case (state)
        IDLE: begin
          if (grant_core_c || grant_dbg_c) begin
            state    <= ACCESS;
            enable_n <= 1'b0;
            wait_cnt <= '0;
            if (grant_dbg_c) begin
              owner      <= OWNER_DBG;
              cmd        <= dbg_cmd_c;
              starve_cnt <= '0;
            end else begin
              owner <= OWNER_CORE;
              cmd   <= core_cmd_c;
              if (bus.dbg_req && (starve_cnt != SC_W'(STARVE_LIMIT)))
                starve_cnt <= starve_cnt + SC_W'(1);
            end
          end
        end
        ACCESS: begin
          wait_cnt <= wait_cnt + WC_W'(1);
          if (finish_c) begin
            state    <= RESP;
            enable_n <= 1'b1;
            if (owner == OWNER_DBG) begin
              dbg_ack   <= 1'b1;
              dbg_rdata <= resp_rdata_c;
              dbg_fault <= resp_fault_c;
            end else begin
              core_ack   <= 1'b1;
              core_rdata <= resp_rdata_c;
              core_fault <= resp_fault_c;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_enable_n    = enable_n;
  assign bus.mem_is_write    = cmd.is_write;
  assign bus.mem_is_unsigned = cmd.is_unsigned;
  assign bus.mem_op_size     = cmd.op_size;
  assign bus.mem_addr        = cmd.addr;
  assign bus.mem_in          = cmd.wdata;

  assign bus.core_ack        = core_ack;
  assign bus.core_rdata      = core_rdata;
  assign bus.core_fault_num  = core_fault;
  assign bus.dbg_ack         = dbg_ack;
  assign bus.dbg_rdata       = dbg_rdata;
  assign bus.dbg_fault_num   = dbg_fault;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter: expected responses queued at request time.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    owner_e      owner;
    logic        is_write;
    logic        is_unsigned;
    logic [1:0]  op_size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [2:0]  fault;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .STARVE_LIMIT (4),
    .TIMEOUT      (15)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input owner_e who, input logic wr, input logic uns, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    if (who == OWNER_CORE) begin
      bus.core_is_write = wr; bus.core_is_unsigned = uns; bus.core_op_size = sz;
      bus.core_addr = a; bus.core_wdata = wd; bus.core_req = 1'b1;
    end else begin
      bus.dbg_is_write = wr; bus.dbg_is_unsigned = uns; bus.dbg_op_size = sz;
      bus.dbg_addr = a; bus.dbg_wdata = wd; bus.dbg_req = 1'b1;
    end
  endtask

  task automatic expect_resp(input owner_e who, input logic wr, input logic uns, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                             input logic [2:0] ft);
    exp_t e;
    e.owner = who; e.is_write = wr; e.is_unsigned = uns; e.op_size = sz;
    e.addr = a; e.wdata = wd; e.rdata = rd; e.fault = ft;
    sb.push_back(e);
  endtask

  // Wait for grant, play memory for one access, then check the ack against the queue head.
  task automatic run_access(input int exp_wait, input int done_at, input logic [31:0] mdata,
                            input logic [2:0] mflt, input int exp_len, input bit perturb);
    exp_t e;
    int   n;
    int   len;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb[0];
    n = 0;
    while (bus.mem_enable_n && n < 10) begin cyc(); n++; end
    check("grant_latency", 32'(n), 32'(exp_wait));
    check("mem_is_write", 32'(bus.mem_is_write), 32'(e.is_write));
    check("mem_is_unsigned", 32'(bus.mem_is_unsigned), 32'(e.is_unsigned));
    check("mem_op_size", 32'(bus.mem_op_size), 32'(e.op_size));
    check("mem_in", bus.mem_in, e.wdata);
    len = 0;
    while (!bus.mem_enable_n && len < 40) begin
      check("mem_addr_stable", bus.mem_addr, e.addr);
      len++;
      if (perturb && len == 1) bus.core_addr = 32'h300;
      if (len == done_at) begin
        bus.mem_done = 1'b1; bus.mem_out = mdata; bus.mem_fault_num = mflt;
      end
      cyc();
      bus.mem_done = 1'b0;
    end
    check("access_len", 32'(len), 32'(exp_len));
    e = sb.pop_front();
    check("core_ack", 32'(bus.core_ack), 32'(e.owner == OWNER_CORE));
    check("dbg_ack", 32'(bus.dbg_ack), 32'(e.owner == OWNER_DBG));
    if (e.owner == OWNER_CORE) begin
      check("core_rdata", bus.core_rdata, e.rdata);
      check("core_fault", 32'(bus.core_fault_num), 32'(e.fault));
      check("dbg_rdata_idle", bus.dbg_rdata, 32'd0);
    end else begin
      check("dbg_rdata", bus.dbg_rdata, e.rdata);
      check("dbg_fault", 32'(bus.dbg_fault_num), 32'(e.fault));
      check("core_rdata_idle", bus.core_rdata, 32'd0);
    end
  endtask

  initial begin
    int ack_seen;
    reset_n = 1'b0;
    bus.core_req = 1'b0; bus.core_is_write = 1'b0; bus.core_is_unsigned = 1'b0;
    bus.core_op_size = '0; bus.core_addr = '0; bus.core_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_is_write = 1'b0; bus.dbg_is_unsigned = 1'b0;
    bus.dbg_op_size = '0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    bus.mem_out = '0; bus.mem_fault_num = '0; bus.mem_done = 1'b0;

    // Reset values
    repeat (3) cyc();
    check("rst_enable_n", 32'(bus.mem_enable_n), 32'd1);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_is_write", 32'(bus.mem_is_write), 32'd0);
    check("rst_mem_op_size", 32'(bus.mem_op_size), 32'd0);
    check("rst_core_ack", 32'(bus.core_ack), 32'd0);
    check("rst_dbg_ack", 32'(bus.dbg_ack), 32'd0);
    check("rst_core_rdata", bus.core_rdata, 32'd0);
    check("rst_dbg_fault", 32'(bus.dbg_fault_num), 32'd0);
    reset_n = 1'b1;
    cyc();

    // mem_done outside ACCESS is ignored
    bus.mem_done = 1'b1;
    repeat (2) cyc();
    bus.mem_done = 1'b0;
    check("idle_done_enable_n", 32'(bus.mem_enable_n), 32'd1);
    check("idle_done_ack", 32'(bus.core_ack | bus.dbg_ack), 32'd0);

    // Core read, done after 2 cycles; core_addr changed mid-access
    drive(OWNER_CORE, 1'b0, 1'b0, SIZE_WORD, 32'h100, 32'h0);
    expect_resp(OWNER_CORE, 1'b0, 1'b0, SIZE_WORD, 32'h100, 32'h0, 32'hDEADBEEF, 3'd0);
    run_access(1, 2, 32'hDEADBEEF, 3'd0, 2, 1'b1);
    bus.core_req = 1'b0;
    cyc();
    check("ack_one_pulse", 32'(bus.core_ack), 32'd0);
    check("rdata_cleared", bus.core_rdata, 32'd0);

    // Debug write timeout
    bus.mem_out = 32'hFFFF_FFFF;
    drive(OWNER_DBG, 1'b1, 1'b0, SIZE_WORD, 32'h200, 32'h1234_5678);
    expect_resp(OWNER_DBG, 1'b1, 1'b0, SIZE_WORD, 32'h200, 32'h1234_5678, 32'd0, FAULT_BUS_TIMEOUT);
    run_access(1, 99, 32'hFFFF_FFFF, 3'd5, 15, 1'b0);
    bus.dbg_req = 1'b0;
    cyc();

    // mem_done coincides with timeout
    drive(OWNER_CORE, 1'b0, 1'b1, SIZE_HALF, 32'h180, 32'h0);
    expect_resp(OWNER_CORE, 1'b0, 1'b1, SIZE_HALF, 32'h180, 32'h0, 32'h0000_CAFE, 3'b010);
    run_access(1, 15, 32'h0000_CAFE, 3'b010, 15, 1'b0);
    bus.core_req = 1'b0;
    cyc();

    // Starvation: both held, expect core x4, dbg, core
    drive(OWNER_CORE, 1'b0, 1'b0, SIZE_BYTE, 32'h400, 32'h0);
    drive(OWNER_DBG, 1'b1, 1'b0, SIZE_WORD, 32'h500, 32'hA0A0_0505);
    for (int i = 0; i < 6; i++) begin
      if (i == 4)
        expect_resp(OWNER_DBG, 1'b1, 1'b0, SIZE_WORD, 32'h500, 32'hA0A0_0505, 32'(32'h1000 + i), 3'd0);
      else
        expect_resp(OWNER_CORE, 1'b0, 1'b0, SIZE_BYTE, 32'h400, 32'h0, 32'(32'h1000 + i), 3'd0);
    end
    for (int i = 0; i < 6; i++)
      run_access((i == 0) ? 1 : 2, 1, 32'(32'h1000 + i), 3'd0, 1, 1'b0);
    bus.core_req = 1'b0;
    bus.dbg_req = 1'b0;
    cyc();

    // Reset during ACCESS: no ack, then fresh request works
    drive(OWNER_CORE, 1'b0, 1'b0, SIZE_WORD, 32'h600, 32'h0);
    cyc();
    check("pre_rst_enable_n", 32'(bus.mem_enable_n), 32'd0);
    cyc();
    reset_n = 1'b0;
    bus.core_req = 1'b0;
    cyc();
    check("mid_rst_enable_n", 32'(bus.mem_enable_n), 32'd1);
    check("mid_rst_mem_addr", bus.mem_addr, 32'd0);
    reset_n = 1'b1;
    ack_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.core_ack || bus.dbg_ack) ack_seen++;
      cyc();
    end
    check("no_ack_after_reset", 32'(ack_seen), 32'd0);
    drive(OWNER_CORE, 1'b0, 1'b0, SIZE_WORD, 32'h700, 32'h0);
    expect_resp(OWNER_CORE, 1'b0, 1'b0, SIZE_WORD, 32'h700, 32'h0, 32'hA5A5_A5A5, 3'd0);
    run_access(1, 3, 32'hA5A5_A5A5, 3'd0, 3, 1'b0);
    bus.core_req = 1'b0;
    cyc();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
